// File: rtl/eth_fifo_ctrl_if.sv
// rtl/eth_fifo_ctrl_if.sv - FIFO access-side handshake and status bundle
interface eth_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [SIZE:0]         cnt;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, full, empty, almost_full, almost_empty, cnt, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, full, empty, almost_full, almost_empty, cnt, overflow, underflow
  );
endinterface

// File: rtl/eth_fifo_ctrl.sv
// rtl/eth_fifo_ctrl.sv - first-word-fall-through controller for the Ethernet FIFO memory macro
module eth_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter int AF_LEVEL   = (1 << SIZE) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  eth_fifo_ctrl_if.slave        fifo,
  output logic                  mem_we,
  output logic [SIZE-1:0]       mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [SIZE-1:0]       mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [SIZE:0] DEPTH_C = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0] AF_C    = AF_LEVEL[SIZE:0];
  localparam logic [SIZE:0] AE_C    = AE_LEVEL[SIZE:0];

  logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [SIZE:0]   mem_cnt_q, mem_cnt_d;
  logic [SIZE:0]   cnt_q, cnt_d;
  logic            head_valid_q, head_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic flush;
  logic full_w;
  logic pop_acc;
  logic push_acc;
  logic fetch;

  always_comb begin
    flush  = reset | clear;
    full_w = (cnt_q == DEPTH_C);
    // A pop frees a slot in the same cycle, so push at full is still legal alongside it.
    pop_acc  = fifo.pop & head_valid_q & ~flush;
    push_acc = fifo.push & (~full_w | pop_acc) & ~flush;
    fetch    = (mem_cnt_q != '0) & (~head_valid_q | pop_acc) & ~flush;

    wr_ptr_d     = wr_ptr_q + SIZE'(push_acc);
    rd_ptr_d     = rd_ptr_q + SIZE'(fetch);
    mem_cnt_d    = mem_cnt_q + (SIZE+1)'(push_acc) - (SIZE+1)'(fetch);
    cnt_d        = cnt_q + (SIZE+1)'(push_acc) - (SIZE+1)'(pop_acc);
    head_valid_d = fetch | (head_valid_q & ~pop_acc);
    overflow_d   = overflow_q | (fifo.push & full_w & ~pop_acc);
    underflow_d  = underflow_q | (fifo.pop & ~head_valid_q);

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      mem_cnt_d    = '0;
      cnt_d        = '0;
      head_valid_d = 1'b0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      cnt_q        <= '0;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      cnt_q        <= cnt_d;
      head_valid_q <= head_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign mem_we    = push_acc;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = fifo.data_in;
  assign mem_re    = fetch;
  assign mem_raddr = rd_ptr_q;

  // The head word lives on the macro output register; it is held while mem_re is low.
  assign fifo.data_out     = mem_rdata;
  assign fifo.empty        = ~head_valid_q;
  assign fifo.full         = full_w;
  assign fifo.almost_full  = (cnt_q >= AF_C);
  assign fifo.almost_empty = (cnt_q <= AE_C);
  assign fifo.cnt          = cnt_q;
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_eth_fifo_ctrl.sv
// tb/tb_eth_fifo_ctrl.sv - self-checking bench for eth_fifo_ctrl with a registered-read memory model
module tb_eth_fifo_ctrl;
  localparam int DW = 32;
  localparam int SZ = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic          mem_we, mem_re;
  logic [SZ-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [DEPTH];

  eth_fifo_ctrl_if #(.DATA_WIDTH(DW), .SIZE(SZ)) bus ();

  eth_fifo_ctrl #(.DATA_WIDTH(DW), .SIZE(SZ), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .fifo(bus),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  int checks = 0;
  int errors = 0;

  int          m_cnt, m_mc;
  bit          m_hv, m_ovf, m_udf;
  logic [SZ-1:0] m_wp, m_rp;
  logic [DW-1:0] sb [$];

  typedef struct {
    bit          push, pop, clr;
    logic [DW-1:0] din;
    int          exp_cnt;
    bit          exp_empty;
    logic [DW-1:0] exp_dout;
    bit          exp_udf;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mc = 0; m_hv = 0; m_ovf = 0; m_udf = 0; m_wp = '0; m_rp = '0;
    sb.delete();
  endtask

  task automatic step(input bit p, input bit po, input bit c, input logic [DW-1:0] d);
    bit pa, wa, ra;
    bus.push = p; bus.pop = po; clear = c; bus.data_in = d;
    @(negedge clk);
    pa = po && m_hv && !c;
    wa = p && ((m_cnt != DEPTH) || pa) && !c;
    ra = (m_mc != 0) && (!m_hv || pa) && !c;
    chk("mem_we", 64'(mem_we), 64'(wa));
    chk("mem_re", 64'(mem_re), 64'(ra));
    if (wa) chk("mem_waddr", 64'(mem_waddr), 64'(m_wp));
    if (ra) chk("mem_raddr", 64'(mem_raddr), 64'(m_rp));
    if (pa) begin
      if (sb.size() == 0) chk("sb_nonempty", 64'(0), 64'(1));
      else chk("data_out", 64'(bus.data_out), 64'(sb.pop_front()));
    end
    if (c) model_reset();
    else begin
      if (wa) sb.push_back(d);
      if (po && !m_hv) m_udf = 1;
      if (p && m_cnt == DEPTH && !pa) m_ovf = 1;
      m_wp  = m_wp + SZ'(wa);
      m_rp  = m_rp + SZ'(ra);
      m_mc  = m_mc + int'(wa) - int'(ra);
      m_cnt = m_cnt + int'(wa) - int'(pa);
      m_hv  = ra || (m_hv && !pa);
    end
    @(posedge clk); #1;
    chk("cnt", 64'(bus.cnt), 64'(m_cnt));
    chk("empty", 64'(bus.empty), 64'(!m_hv));
    chk("full", 64'(bus.full), 64'(m_cnt == DEPTH));
    chk("almost_full", 64'(bus.almost_full), 64'(m_cnt >= 12));
    chk("almost_empty", 64'(bus.almost_empty), 64'(m_cnt <= 4));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("underflow", 64'(bus.underflow), 64'(m_udf));
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 32'h11, 1, 1, 32'h0,  0};
    vecs[1] = '{1, 0, 0, 32'h22, 2, 0, 32'h11, 0};
    vecs[2] = '{1, 0, 0, 32'h33, 3, 0, 32'h11, 0};
    vecs[3] = '{0, 1, 0, 32'h0,  2, 0, 32'h22, 0};
    vecs[4] = '{0, 1, 0, 32'h0,  1, 0, 32'h33, 0};
    vecs[5] = '{0, 1, 0, 32'h0,  0, 1, 32'h0,  0};
    vecs[6] = '{0, 1, 0, 32'h0,  0, 1, 32'h0,  1};
    vecs[7] = '{0, 0, 0, 32'h0,  0, 1, 32'h0,  1};
    vecs[8] = '{0, 0, 1, 32'h0,  0, 1, 32'h0,  0};

    reset = 1'b1; clear = 1'b0;
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 32'hBAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_we", 64'(mem_we), 64'(0));
    chk("reset_mem_re", 64'(mem_re), 64'(0));
    bus.push = 1'b0; bus.pop = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_cnt", 64'(bus.cnt), 64'(0));
    chk("rst_empty", 64'(bus.empty), 64'(1));
    chk("rst_full", 64'(bus.full), 64'(0));
    chk("rst_af", 64'(bus.almost_full), 64'(0));
    chk("rst_ae", 64'(bus.almost_empty), 64'(1));
    chk("rst_ovf", 64'(bus.overflow), 64'(0));
    chk("rst_udf", 64'(bus.underflow), 64'(0));
    chk("rst_waddr", 64'(mem_waddr), 64'(0));
    chk("rst_raddr", 64'(mem_raddr), 64'(0));

    // Directed vectors: fall-through latency, ordered drain, underflow and its clear.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d_cnt", i), 64'(bus.cnt), 64'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_empty", i), 64'(bus.empty), 64'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_udf", i), 64'(bus.underflow), 64'(vecs[i].exp_udf));
      if (!vecs[i].exp_empty)
        chk($sformatf("vec%0d_dout", i), 64'(bus.data_out), 64'(vecs[i].exp_dout));
    end

    // Fill to full, overflow, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 32'h100 + i);
      chk("fill_af", 64'(bus.almost_full), 64'((i + 1) >= 12));
      chk("fill_full", 64'(bus.full), 64'((i + 1) == 16));
    end
    step(1, 0, 0, 32'hDEAD);
    chk("ovf_set", 64'(bus.overflow), 64'(1));
    chk("ovf_cnt", 64'(bus.cnt), 64'(16));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(bus.data_out), 64'(32'h100 + i));
      step(0, 1, 0, 0);
    end
    chk("drain_empty", 64'(bus.empty), 64'(1));
    step(0, 0, 1, 0);

    // Offset pointers so the full/push+pop case crosses the wrap.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h200 + i);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h300 + i);
    step(1, 1, 0, 32'hAA);
    chk("pp_full_ovf", 64'(bus.overflow), 64'(0));
    chk("pp_full_cnt", 64'(bus.cnt), 64'(16));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 15) chk("aa_16th", 64'(bus.data_out), 64'(32'hAA));
      step(0, 1, 0, 0);
    end

    // Random streaming, gated by full/empty.
    for (int i = 0; i < 1000; i++) begin
      step(bit'($urandom_range(0, 1)) && !bus.full, bit'($urandom_range(0, 1)) && !bus.empty, 0, $urandom);
    end

    // Clear mid-stream with push and pop both requested.
    step(1, 0, 0, 32'h71);
    step(1, 0, 0, 32'h72);
    step(1, 1, 1, 32'h73);
    chk("clr_cnt", 64'(bus.cnt), 64'(0));
    chk("clr_empty", 64'(bus.empty), 64'(1));
    chk("clr_ovf", 64'(bus.overflow), 64'(0));
    chk("clr_udf", 64'(bus.underflow), 64'(0));
    chk("clr_waddr", 64'(mem_waddr), 64'(0));
    chk("clr_raddr", 64'(mem_raddr), 64'(0));
    step(1, 0, 0, 32'h55);
    chk("post_clr_cnt", 64'(bus.cnt), 64'(1));
    chk("post_clr_empty1", 64'(bus.empty), 64'(1));
    step(0, 0, 0, 0);
    chk("post_clr_empty0", 64'(bus.empty), 64'(0));
    chk("post_clr_dout", 64'(bus.data_out), 64'(32'h55));
    step(0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
